uart_rx_deser: RTL and testbench

//   Parametrised UART receive deserializer for the WimpFi receive path.
//   - Accepts one sampled bit per shen strobe from the receive bit-timing logic.
//   - Tracks the bit position and captures an optional parity bit.
//   - Raises a one-cycle frame-done strobe once the word is assembled.
//   - Adds configurable bit order, word width, parity check and a frame-restart clear.

---
 rtl/uart_rx_deser_if.sv | 31 +++
 rtl/uart_rx_deser.sv | 122 ++++++++++++
 tb/tb_uart_rx_deser.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deser_if.sv
// Bus bundle for uart_rx_deser: frame-control inputs, serial bit input,
// parallel load path, and the assembled-word/status outputs.
//   master : bit-timing / test side (drives clr, shen, s_in, par_odd, lden, d)
//   slave  : deserializer side (drives q, cnt, busy, done, par_err)
interface uart_rx_deser_if #(
    parameter int unsigned W = 8
) ();
    localparam int unsigned CW = $clog2(W + 2);

    logic          clr;
    logic          shen;
    logic          s_in;
    logic          par_odd;
    logic          lden;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
    logic          par_err;

    modport master (
        output clr, shen, s_in, par_odd, lden, d,
        input  q, cnt, busy, done, par_err
    );

    modport slave (
        input  clr, shen, s_in, par_odd, lden, d,
        output q, cnt, busy, done, par_err
    );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer for the WimpFi receive path.
// Takes one sampled bit per shen strobe, assembles a W-bit word (LSB- or
// MSB-first), optionally checks a trailing parity bit, and pulses done for
// one cycle when the frame is complete.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active-low
//   bus    : uart_rx_deser_if.slave
//            in : clr, shen, s_in, par_odd, lden, d[W-1:0]
//            out: q[W-1:0], cnt[$clog2(W+2)-1:0], busy, done, par_err
module uart_rx_deser #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_deser_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 2);

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PAR  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e        state_q;
    logic [W-1:0]  q_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          busy_q;
    logic          par_err_q;

    logic [W-1:0]  shift_d;
    logic          last_data_c;
    logic          par_err_d;

    // Word after shifting in the current serial bit, per bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_d = {q_q[W-2:0], bus.s_in};
        end else begin : g_lsb_first
            assign shift_d = {bus.s_in, q_q[W-1:1]};
        end
    endgenerate

    // This shen fills the last data bit.
    assign last_data_c = (cnt_q == CW'(W - 1));

    // Parity over data plus received parity bit, compared against the mode.
    assign par_err_d = ((^q_q) ^ bus.s_in) != bus.par_odd;

    // Frame FSM and datapath; priority rst_n > clr > lden > shen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_DATA;
            q_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else if (bus.clr) begin
            state_q   <= ST_DATA;
            q_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else if (bus.lden) begin
            state_q   <= ST_HOLD;
            q_q       <= bus.d;
            cnt_q     <= CW'(W);
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.shen) begin
                case (state_q)
                    ST_DATA: begin
                        q_q   <= shift_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_data_c) begin
                            if (PARITY_EN) begin
                                state_q <= ST_PAR;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_HOLD;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                    ST_PAR: begin
                        cnt_q     <= CW'(W + 1);
                        par_err_q <= par_err_d;
                        state_q   <= ST_HOLD;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                    ST_HOLD: begin
                        // Frame complete: extra strobes are dropped.
                    end
                    default: begin
                        state_q <= ST_DATA;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q       = q_q;
    assign bus.cnt     = cnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.par_err = par_err_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Testbench for uart_rx_deser: an LSB-first and an MSB-first instance see the
// same bit stream; frame results are queued at stimulus time and checked by
// per-instance monitors whenever done is seen.
module tb_uart_rx_deser;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 2);

    typedef struct packed {
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          pe;
    } exp_t;

    logic clk;
    logic rst_n;
    logic mon_en;
    int   n_chk;
    int   n_fail;
    exp_t exp_lsb[$];
    exp_t exp_msb[$];
    exp_t e_l;
    exp_t e_m;

    uart_rx_deser_if #(.W(W)) lsb_if ();
    uart_rx_deser_if #(.W(W)) msb_if ();

    uart_rx_deser #(.W(W), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lsb_if)
    );

    uart_rx_deser #(.W(W), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (msb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: any done must match the next queued frame result.
    always @(negedge clk) begin
        if (mon_en && lsb_if.done === 1'b1) begin
            if (exp_lsb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL lsb_unexpected_done: got done=1, expected no frame");
            end else begin
                e_l = exp_lsb.pop_front();
                chk("lsb_mon_q",   32'(lsb_if.q),       32'(e_l.q));
                chk("lsb_mon_cnt", 32'(lsb_if.cnt),     32'(e_l.cnt));
                chk("lsb_mon_pe",  32'(lsb_if.par_err), 32'(e_l.pe));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && msb_if.done === 1'b1) begin
            if (exp_msb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL msb_unexpected_done: got done=1, expected no frame");
            end else begin
                e_m = exp_msb.pop_front();
                chk("msb_mon_q",   32'(msb_if.q),       32'(e_m.q));
                chk("msb_mon_cnt", 32'(msb_if.cnt),     32'(e_m.cnt));
                chk("msb_mon_pe",  32'(msb_if.par_err), 32'(e_m.pe));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic [W-1:0] dv,
                          input logic sh, input logic si, input logic po);
        lsb_if.clr = c;  msb_if.clr = c;
        lsb_if.lden = l; msb_if.lden = l;
        lsb_if.d = dv;   msb_if.d = dv;
        lsb_if.shen = sh; msb_if.shen = sh;
        lsb_if.s_in = si; msb_if.s_in = si;
        lsb_if.par_odd = po; msb_if.par_odd = po;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic shen_bit(input logic b, input logic po);
        set_in(1'b0, 1'b0, '0, 1'b1, b, po);
        tick();
        idle();
    endtask

    task automatic clr_pulse();
        set_in(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic check_both(input string tag, input logic [W-1:0] ql, input logic [W-1:0] qm,
                              input int c, input logic pe, input logic bz, input logic dn);
        chk({tag, "_lsb_q"},    32'(lsb_if.q),       32'(ql));
        chk({tag, "_msb_q"},    32'(msb_if.q),       32'(qm));
        chk({tag, "_lsb_cnt"},  32'(lsb_if.cnt),     32'(c));
        chk({tag, "_msb_cnt"},  32'(msb_if.cnt),     32'(c));
        chk({tag, "_lsb_pe"},   32'(lsb_if.par_err), 32'(pe));
        chk({tag, "_msb_pe"},   32'(msb_if.par_err), 32'(pe));
        chk({tag, "_lsb_busy"}, 32'(lsb_if.busy),    32'(bz));
        chk({tag, "_msb_busy"}, 32'(msb_if.busy),    32'(bz));
        chk({tag, "_lsb_done"}, 32'(lsb_if.done),    32'(dn));
        chk({tag, "_msb_done"}, 32'(msb_if.done),    32'(dn));
    endtask

    // Full frame: clr, 8 data bits (b[0] sent first), then the parity bit.
    task automatic frame(input string tag, input logic [7:0] b, input logic pbit, input logic po,
                         input logic [W-1:0] el, input logic [W-1:0] em, input logic pe);
        clr_pulse();
        for (int i = 0; i < 8; i++) begin
            shen_bit(b[i], po);
            if (i == 0) begin
                chk({tag, "_lsb_busy1"}, 32'(lsb_if.busy), 32'd1);
                chk({tag, "_lsb_cnt1"},  32'(lsb_if.cnt),  32'd1);
            end
        end
        chk({tag, "_lsb_par_busy"}, 32'(lsb_if.busy), 32'd1);
        chk({tag, "_msb_par_cnt"},  32'(msb_if.cnt),  32'd8);
        exp_lsb.push_back('{q: el, cnt: CW'(9), pe: pe});
        exp_msb.push_back('{q: em, cnt: CW'(9), pe: pe});
        shen_bit(pbit, po);
        check_both({tag, "_done"}, el, em, 9, pe, 1'b0, 1'b1);
        tick();
        check_both({tag, "_after"}, el, em, 9, pe, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        idle();
        tick();
        tick();
        check_both("reset", 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 1: 1,0,1,0,1,0,1,0 even parity, parity bit 0
        frame("t1", 8'b0101_0101, 1'b0, 1'b0, 8'h55, 8'hAA, 1'b0);
        // 2: wrong parity bit, then odd parity with parity bit 1
        frame("t2a", 8'b0101_0101, 1'b1, 1'b0, 8'h55, 8'hAA, 1'b1);
        frame("t2b", 8'b0101_0101, 1'b1, 1'b1, 8'h55, 8'hAA, 1'b0);
        // 3: 1,0,1,0,0,0,1,1 -> MSB-first A3, LSB-first C5
        frame("t3", 8'b1100_0101, 1'b0, 1'b0, 8'hC5, 8'hA3, 1'b0);

        // 4: clr mid-frame, then a clean 3C frame, then clr together with shen
        clr_pulse();
        for (int i = 0; i < 4; i++) shen_bit(1'b1, 1'b0);
        chk("t4_mid_cnt", 32'(lsb_if.cnt), 32'd4);
        clr_pulse();
        check_both("t4_clr", 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        frame("t4", 8'b0011_1100, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0);
        set_in(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check_both("t4_clr_shen", 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);

        // 5: reset during the parity bit, then extra shen while in HOLD
        clr_pulse();
        for (int i = 0; i < 8; i++) shen_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        idle();
        check_both("t5_rst", 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        tick();
        frame("t5", 8'b0101_0101, 1'b1, 1'b0, 8'h55, 8'hAA, 1'b1);
        shen_bit(1'b1, 1'b0);
        check_both("t5_extra", 8'h55, 8'hAA, 9, 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        // 6: parallel load, then lden together with shen mid-frame
        clr_pulse();
        for (int i = 0; i < 3; i++) shen_bit(1'b1, 1'b0);
        set_in(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check_both("t6_lden", 8'hC3, 8'hC3, 8, 1'b0, 1'b0, 1'b0);
        tick();
        clr_pulse();
        for (int i = 0; i < 3; i++) shen_bit(1'b1, 1'b0);
        set_in(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check_both("t6_lden_shen", 8'h5A, 8'h5A, 8, 1'b0, 1'b0, 1'b0);
        shen_bit(1'b0, 1'b0);
        check_both("t6_hold", 8'h5A, 8'h5A, 8, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        chk("lsb_queue_drained", 32'(exp_lsb.size()), 32'd0);
        chk("msb_queue_drained", 32'(exp_msb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
